// File: rtl/identify_issue_ctrl_if.sv
// Bundles the fetch, Identify and branch-unit signals of identify_issue_ctrl.
//   master : environment side (drives i_*, observes o_*)
//   slave  : controller side (observes i_*, drives o_*)
// Fetch    : i_fetch_valid, i_fetch_word[0:31], o_fetch_ready, i_flush
// Identify : o_id_en, o_id_instr[0:63], o_id_prefixed, i_id_ready, i_bu_en
// Branch   : i_br_resolved, o_wait_branch
// Status   : o_err_prefix
interface identify_issue_ctrl_if;
   logic        i_fetch_valid;
   logic [0:31] i_fetch_word;
   logic        o_fetch_ready;
   logic        i_flush;
   logic        o_id_en;
   logic [0:63] o_id_instr;
   logic        o_id_prefixed;
   logic        i_id_ready;
   logic        i_bu_en;
   logic        i_br_resolved;
   logic        o_wait_branch;
   logic        o_err_prefix;

   modport master (
      output i_fetch_valid, i_fetch_word, i_flush, i_id_ready, i_bu_en, i_br_resolved,
      input  o_fetch_ready, o_id_en, o_id_instr, o_id_prefixed, o_wait_branch, o_err_prefix
   );

   modport slave (
      input  i_fetch_valid, i_fetch_word, i_flush, i_id_ready, i_bu_en, i_br_resolved,
      output o_fetch_ready, o_id_en, o_id_instr, o_id_prefixed, o_wait_branch, o_err_prefix
   );
endinterface

// File: rtl/identify_issue_ctrl.sv
// Issue sequencer in front of the Identify stage. Fetch words are buffered in
// a DEPTH-entry FIFO; a prefix word (opcode 000001) is merged with its suffix
// into a single 64-bit issue. One instruction at a time is presented with a
// registered valid/ready handshake, and issue stalls after any branch until
// the branch unit signals resolution.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous reset, active low
//   bus    - identify_issue_ctrl_if.slave (fetch, Identify, branch, status)
//
// state   | meaning
// RUN     | instructions are loaded into the output stage as they complete
// WAIT_BR | a branch was handed to Identify; no loads until i_br_resolved
module identify_issue_ctrl #(
   parameter int DEPTH = 4
) (
   input logic                  i_clk,
   input logic                  i_rst,
   identify_issue_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {RUN, WAIT_BR} state_t;

   state_t        state_q, state_d;
   logic [0:31]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          id_en_q, id_en_d;
   logic [0:63]   id_instr_q, id_instr_d;
   logic          id_prefixed_q, id_prefixed_d;
   logic          err_prefix_q, err_prefix_d;

   logic [0:31]   head, next_w;
   logic          head_pfx, next_pfx;
   logic          fetch_ready, push, transfer, enter_wait, can_load;
   logic          load_one, load_two, drop_head;
   logic [1:0]    pop_n;

   assign head     = mem_q[rd_ptr_q];
   assign next_w   = mem_q[rd_ptr_q + AW'(1)];
   assign head_pfx = (head[0:5] == 6'b000001);
   assign next_pfx = (next_w[0:5] == 6'b000001);

   // Held low in reset so fetch never sees a ready FIFO it cannot write.
   assign fetch_ready = i_rst & (count_q != FULL);
   assign push        = bus.i_fetch_valid & fetch_ready & ~bus.i_flush;
   assign transfer    = id_en_q & bus.i_id_ready;

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      id_en_d       = id_en_q;
      id_instr_d    = id_instr_q;
      id_prefixed_d = id_prefixed_q;
      err_prefix_d  = 1'b0;

      // The edge that hands a branch to Identify must not load the next
      // instruction behind it.
      enter_wait = (state_q == RUN) & transfer & bus.i_bu_en;
      can_load   = (state_q == RUN) & (~id_en_q | transfer) & ~enter_wait;
      load_one   = can_load & (count_q != '0) & ~head_pfx;
      load_two   = can_load & (count_q >= CW'(2)) & head_pfx & ~next_pfx;
      // Two prefixes in a row: discard the first, retry with the second.
      drop_head  = can_load & (count_q >= CW'(2)) & head_pfx & next_pfx;

      if (load_two)
         pop_n = 2'd2;
      else if (load_one | drop_head)
         pop_n = 2'd1;
      else
         pop_n = 2'd0;

      if (bus.i_flush) begin
         state_d  = RUN;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         id_en_d  = 1'b0;
      end else begin
         wr_ptr_d     = wr_ptr_q + AW'(push);
         rd_ptr_d     = rd_ptr_q + AW'(pop_n);
         count_d      = count_q + CW'(push) - CW'(pop_n);
         err_prefix_d = drop_head;

         if (load_one) begin
            id_en_d       = 1'b1;
            id_instr_d    = {head, 32'h0};
            id_prefixed_d = 1'b0;
         end else if (load_two) begin
            id_en_d       = 1'b1;
            id_instr_d    = {head, next_w};
            id_prefixed_d = 1'b1;
         end else if (transfer) begin
            id_en_d = 1'b0;
         end

         if (enter_wait)
            state_d = WAIT_BR;
         else if ((state_q == WAIT_BR) & bus.i_br_resolved)
            state_d = RUN;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q       <= RUN;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         id_en_q       <= 1'b0;
         id_instr_q    <= '0;
         id_prefixed_q <= 1'b0;
         err_prefix_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         id_en_q       <= id_en_d;
         id_instr_q    <= id_instr_d;
         id_prefixed_q <= id_prefixed_d;
         err_prefix_q  <= err_prefix_d;
      end
   end

   // Storage needs no reset: count_q gates every read.
   always_ff @(posedge i_clk) begin
      if (push)
         mem_q[wr_ptr_q] <= bus.i_fetch_word;
   end

   assign bus.o_fetch_ready = fetch_ready;
   assign bus.o_id_en       = id_en_q;
   assign bus.o_id_instr    = id_instr_q;
   assign bus.o_id_prefixed = id_prefixed_q;
   assign bus.o_wait_branch = (state_q == WAIT_BR);
   assign bus.o_err_prefix  = err_prefix_q;
endmodule
